// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: hazard/redirect inputs from decode, the
// instruction-fetch request/response channel, the fetch buffer view
// presented to IF/ID, and the per-stage load/flush controls.
interface pipe_ctrl_if;
  logic        hz_stall;
  logic        br_redirect;
  logic [63:0] br_target;
  logic        dreq_busy;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        en_if_id;
  logic        en_id_ex;
  logic        en_ex_mem;
  logic        en_mem_wb;
  logic        flush_if_id;
  logic        flush_id_ex;

  // Environment side: drives hazards, redirects and fetch responses.
  modport master (
    output hz_stall, br_redirect, br_target, dreq_busy,
    output iresp_data_ok, iresp_data,
    input  ireq_valid, ireq_addr,
    input  if_valid, if_instr, if_pc,
    input  en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    input  flush_if_id, flush_id_ex
  );

  // Controller side.
  modport slave (
    input  hz_stall, br_redirect, br_target, dreq_busy,
    input  iresp_data_ok, iresp_data,
    output ireq_valid, ireq_addr,
    output if_valid, if_instr, if_pc,
    output en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    output flush_if_id, flush_id_ex
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: a one-entry fetch buffer driven by a
// four-state fetch FSM (IDLE/REQ/FULL/KILL) plus the stage enables and
// flushes derived from data-memory freeze, decode hazards and redirects.
module pipe_ctrl #(
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic         clk,
  input  logic         reset,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_KILL = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [31:0] r_buf;
  logic [63:0] r_if_pc;
  logic [63:0] r_kill_addr;

  state_t      w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic [31:0] w_buf_nxt;
  logic [63:0] w_if_pc_nxt;
  logic [63:0] w_kill_addr_nxt;

  logic        w_freeze;
  logic        w_stall;
  logic        w_redir;
  logic        w_if_valid;
  logic        w_en_if_id;
  logic        w_en_back;
  logic        w_flush_if_id;
  logic        w_flush_id_ex;
  logic        w_ireq_valid;
  logic [63:0] w_ireq_addr;

  // Qualified pipeline events; freeze dominates stall, stall dominates redirect.
  always_comb begin
    w_freeze = bus.dreq_busy;
    w_stall  = !bus.dreq_busy & bus.hz_stall;
    w_redir  = !bus.dreq_busy & !bus.hz_stall & bus.br_redirect;
  end

  // Stage enables and flushes; reset forces everything open with an IF/ID
  // bubble so stale contents drain out of the pipe.
  always_comb begin
    w_if_valid = (r_state == S_FULL);
    if (reset) begin
      w_en_back     = 1'b1;
      w_en_if_id    = 1'b1;
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b0;
    end else begin
      w_en_back     = !w_freeze;
      w_en_if_id    = !w_freeze & !w_stall;
      w_flush_if_id = w_en_if_id & (w_redir | !w_if_valid);
      w_flush_id_ex = w_stall;
    end
  end

  // Fetch request: address held steady across REQ, and KILL keeps issuing
  // the abandoned address until its response drains.
  always_comb begin
    w_ireq_valid = 1'b0;
    w_ireq_addr  = r_pc;
    unique case (r_state)
      S_REQ:   w_ireq_valid = !reset;
      S_KILL: begin
        w_ireq_valid = !reset;
        w_ireq_addr  = r_kill_addr;
      end
      default: ;
    endcase
  end

  // Fetch FSM next-state; runs through freeze, only consumption is gated.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_buf_nxt       = r_buf;
    w_if_pc_nxt     = r_if_pc;
    w_kill_addr_nxt = r_kill_addr;
    if (w_redir)
      w_pc_nxt = bus.br_target;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (bus.iresp_data_ok) begin
          // A redirect alongside returning data discards it; re-fetch at target.
          if (!w_redir) begin
            w_buf_nxt   = bus.iresp_data;
            w_if_pc_nxt = r_pc;
            w_pc_nxt    = r_pc + 64'd4;
            w_state_nxt = S_FULL;
          end
        end else if (w_redir) begin
          // Outstanding fetch must still be drained before re-requesting.
          w_kill_addr_nxt = r_pc;
          w_state_nxt     = S_KILL;
        end
      end
      S_FULL: begin
        if (w_redir || w_en_if_id)
          w_state_nxt = S_REQ;
      end
      S_KILL: begin
        if (bus.iresp_data_ok)
          w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding fetch by returning to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= PCINIT;
      r_buf       <= '0;
      r_if_pc     <= '0;
      r_kill_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_buf       <= w_buf_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_kill_addr <= w_kill_addr_nxt;
    end
  end

  assign bus.ireq_valid  = w_ireq_valid;
  assign bus.ireq_addr   = w_ireq_addr;
  assign bus.if_valid    = w_if_valid;
  assign bus.if_instr    = r_buf;
  assign bus.if_pc       = r_if_pc;
  assign bus.en_if_id    = w_en_if_id;
  assign bus.en_id_ex    = w_en_back;
  assign bus.en_ex_mem   = w_en_back;
  assign bus.en_mem_wb   = w_en_back;
  assign bus.flush_if_id = w_flush_if_id;
  assign bus.flush_id_ex = w_flush_id_ex;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, fill/consume, hazard stall,
// redirect in REQ (kill path) and FULL, freeze priority, PC wrap and
// reset mid-request.
module tb_pipe_ctrl;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.PCINIT(64'h8000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.hz_stall = 1'b0;
    bus.br_redirect = 1'b0;
    bus.br_target = '0;
    bus.dreq_busy = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data = '0;
    tick();
    tick();

    // reset state
    chk("rst_en_if_id", bus.en_if_id, 1);
    chk("rst_en_mem_wb", bus.en_mem_wb, 1);
    chk("rst_flush_if_id", bus.flush_if_id, 1);
    chk("rst_ireq_valid", bus.ireq_valid, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_if_instr", bus.if_instr, 0);

    // IDLE then REQ at PCINIT
    reset = 1'b0;
    settle();
    chk("idle_ireq_valid", bus.ireq_valid, 0);
    chk("idle_flush_if_id", bus.flush_if_id, 1);
    tick();
    chk("req_valid", bus.ireq_valid, 1);
    chk("req_addr", bus.ireq_addr, 64'h8000_0000);
    tick();
    chk("req_addr_hold", bus.ireq_addr, 64'h8000_0000);
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'h0000_0013;
    bus.hz_stall = 1'b1;  // hold the buffer once it fills
    tick();
    bus.iresp_data_ok = 1'b0;
    settle();
    chk("full_if_valid", bus.if_valid, 1);
    chk("full_if_instr", bus.if_instr, 32'h0000_0013);
    chk("full_if_pc", bus.if_pc, 64'h8000_0000);

    // hazard stall for 3 cycles in FULL
    for (int i = 0; i < 3; i++) begin
      chk("stall_en_if_id", bus.en_if_id, 0);
      chk("stall_en_id_ex", bus.en_id_ex, 1);
      chk("stall_flush_id_ex", bus.flush_id_ex, 1);
      chk("stall_ireq_valid", bus.ireq_valid, 0);
      chk("stall_if_instr", bus.if_instr, 32'h0000_0013);
      chk("stall_if_valid", bus.if_valid, 1);
      tick();
    end
    bus.hz_stall = 1'b0;
    settle();
    chk("consume_en_if_id", bus.en_if_id, 1);
    chk("consume_flush_if_id", bus.flush_if_id, 0);
    tick();
    chk("next_req_addr", bus.ireq_addr, 64'h8000_0004);
    chk("next_req_valid", bus.ireq_valid, 1);

    // redirect in REQ without data: KILL path
    bus.br_redirect = 1'b1;
    bus.br_target = 64'h8000_0100;
    settle();
    chk("redir_req_flush", bus.flush_if_id, 1);
    tick();
    bus.br_redirect = 1'b0;
    settle();
    chk("kill_valid", bus.ireq_valid, 1);
    chk("kill_addr", bus.ireq_addr, 64'h8000_0004);
    tick();
    chk("kill_addr_hold", bus.ireq_addr, 64'h8000_0004);
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'hDEAD_BEEF;
    tick();
    bus.iresp_data_ok = 1'b0;
    settle();
    chk("kill_drop_if_valid", bus.if_valid, 0);
    chk("kill_next_addr", bus.ireq_addr, 64'h8000_0100);
    chk("kill_next_valid", bus.ireq_valid, 1);

    // fill at target, then freeze with stall and redirect all asserted
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'h0000_0093;
    bus.dreq_busy = 1'b1;
    bus.hz_stall = 1'b1;
    bus.br_redirect = 1'b1;
    bus.br_target = 64'h0000_1234;
    tick();
    bus.iresp_data_ok = 1'b0;
    settle();
    chk("frz_if_pc", bus.if_pc, 64'h8000_0100);
    chk("frz_if_valid", bus.if_valid, 1);
    chk("frz_en_if_id", bus.en_if_id, 0);
    chk("frz_en_id_ex", bus.en_id_ex, 0);
    chk("frz_en_ex_mem", bus.en_ex_mem, 0);
    chk("frz_en_mem_wb", bus.en_mem_wb, 0);
    chk("frz_flush_id_ex", bus.flush_id_ex, 0);
    chk("frz_flush_if_id", bus.flush_if_id, 0);
    tick();
    chk("frz_hold_full", bus.if_valid, 1);
    bus.dreq_busy = 1'b0;
    bus.hz_stall = 1'b0;
    bus.br_redirect = 1'b0;
    tick();
    chk("frz_pc_unchanged", bus.ireq_addr, 64'h8000_0104);

    // redirect in FULL drops the buffer, target is FFFF..FC for the wrap check
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'h0000_0033;
    tick();
    bus.iresp_data_ok = 1'b0;
    bus.br_redirect = 1'b1;
    bus.br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    settle();
    chk("full_redir_if_pc", bus.if_pc, 64'h8000_0104);
    chk("full_redir_flush", bus.flush_if_id, 1);
    tick();
    bus.br_redirect = 1'b0;
    settle();
    chk("full_redir_drop", bus.if_valid, 0);
    chk("full_redir_addr", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'h0000_006F;
    tick();
    bus.iresp_data_ok = 1'b0;
    settle();
    chk("wrap_if_pc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_pc_zero", bus.ireq_addr, 64'h0);

    // redirect with data_ok in REQ: data discarded, stay REQ at target
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'h1111_1111;
    bus.br_redirect = 1'b1;
    bus.br_target = 64'h0000_2000;
    tick();
    bus.iresp_data_ok = 1'b0;
    bus.br_redirect = 1'b0;
    settle();
    chk("redir_ok_if_valid", bus.if_valid, 0);
    chk("redir_ok_addr", bus.ireq_addr, 64'h0000_2000);

    // reset mid-request abandons fetch; response in IDLE ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.iresp_data_ok = 1'b1;
    settle();
    chk("mid_rst_ireq_valid", bus.ireq_valid, 0);
    tick();
    bus.iresp_data_ok = 1'b0;
    settle();
    chk("mid_rst_if_valid", bus.if_valid, 0);
    chk("mid_rst_addr", bus.ireq_addr, 64'h8000_0000);
    chk("mid_rst_req", bus.ireq_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
